// File: rtl/pmc_loader_pkg.sv
// pmc_loader_pkg: shared definitions for the PMC code loader.
//   pmc_loader_state_t      loader FSM state encoding
//   PMC_CODE_DEPTH          number of words in the PMC code RAM
//   PMC_LOADER_HOLD_CYCLES  cycles the coprocessor reset is held before the first write
package pmc_loader_pkg;

    localparam int PMC_CODE_DEPTH         = 1024;
    localparam int PMC_LOADER_HOLD_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_HOLD,
        ST_LOAD,
        ST_FLUSH
    } pmc_loader_state_t;

endpackage

// File: rtl/pmc_loader_write_port.sv
// pmc_loader_write_port: registered write stage toward the PMC code RAM.
// It also holds the write address counter.
//   clk, rst_n   clock, synchronous active-low reset
//   load         loads the address counter with load_addr (session start)
//   load_addr    first RAM address of the session
//   accept       a word is accepted this cycle; it is written next cycle
//   wdata        the accepted word
//   mem_addr     registered RAM write address
//   mem_wdata    registered RAM write data
//   mem_we       registered RAM write strobe
module pmc_loader_write_port
    import pmc_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we
);

    logic [ADDR_WIDTH-1:0] addr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= addr_cnt;
                mem_wdata <= wdata;
                addr_cnt  <= addr_cnt + 1'b1;
            end
            // load and accept are never both high: load only happens in IDLE
            if (load) begin
                addr_cnt <= load_addr;
            end
        end
    end

endmodule

// File: rtl/pmc_code_loader.sv
// pmc_code_loader: streams host instruction words into the PMC code RAM.
// The PMC coprocessor is held in reset while a program is being loaded.
//   clk, rst_n            clock, synchronous active-low reset
//   start, abort          begin a session (honoured in IDLE) / cancel it
//   base_addr, word_count session range, sampled on start
//   wdata, wvalid, wready host word stream (valid/ready)
//   mem_addr, mem_wdata, mem_we  registered RAM write port
//   pmcc_rst_n            coprocessor reset, active-low
//   busy, done, error     session in progress / success pulse / sticky error
//   checksum              mod-2^32 sum of the accepted words (PMC_LOADER_CHECKSUM_EN only)
// Optional feature macro: PMC_LOADER_CHECKSUM_EN
//
// state | meaning
// IDLE  | waiting for start
// CHECK | validating the latched range
// HOLD  | coprocessor reset settling before the first write
// LOAD  | accepting words, one per handshake
// FLUSH | last write on the RAM port; release the coprocessor next
module pmc_code_loader
    import pmc_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  pmcc_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
`ifdef PMC_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    pmc_loader_state_t     state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic [1:0]            hold_cnt;
    logic [ADDR_WIDTH+1:0] range_end;
    logic                  range_bad;
    logic                  start_accept;
    logic                  handshake;

    // Two extra bits so base + count cannot overflow before the compare.
    assign range_end    = {2'b00, base_q} + {1'b0, remaining};
    assign range_bad    = (remaining == '0) ||
                          (range_end > (ADDR_WIDTH+2)'(PMC_CODE_DEPTH));
    assign start_accept = (state == ST_IDLE) && start;
    // A handshake that coincides with abort is dropped.
    assign handshake    = (state == ST_LOAD) && wvalid && !abort;
    assign wready       = (state == ST_LOAD);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            remaining  <= '0;
            hold_cnt   <= '0;
            pmcc_rst_n <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        remaining <= word_count;
                        error     <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (range_bad) begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        pmcc_rst_n <= 1'b0;
                        hold_cnt   <= 2'(PMC_LOADER_HOLD_CYCLES - 1);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end else if (hold_cnt == '0) begin
                        state <= ST_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_LOAD: begin
                    // pmcc_rst_n stays low on abort so a partial program never runs
                    if (abort) begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end else if (wvalid) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    pmcc_rst_n <= 1'b1;
                    done       <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PMC_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_accept) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum + 32'(wdata);
        end
    end
`endif

    pmc_loader_write_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_write_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_accept),
        .load_addr(base_addr),
        .accept   (handshake),
        .wdata    (wdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we)
    );

endmodule

// File: tb/tb_pmc_code_loader.sv
// tb_pmc_code_loader: directed bench for pmc_code_loader with a cycle-level
// reference model and literal checks on the key timing points.
module tb_pmc_code_loader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, wvalid;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [DW-1:0] wdata;
    logic          wready, mem_we, pmcc_rst_n, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
`ifdef PMC_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    always #5 clk = ~clk;

    pmc_code_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .pmcc_rst_n(pmcc_rst_n), .busy(busy), .done(done), .error(error)
`ifdef PMC_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t0     = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    endtask

    // ---------------- reference model ----------------
    // Session timeline counted from the start cycle: range verdict at cycle 1,
    // reset hold at cycles 2-3, words accepted from cycle 4 whenever wvalid is
    // high, one flush cycle after the last word, done on the cycle after.
    bit            m_active = 1'b0;
    int            m_t, m_left;
    logic [AW-1:0] m_base, m_addr;
    logic [AW:0]   m_cnt;
    logic          m_err, m_rstn, m_done, m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [31:0]   m_sum;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0; m_err = 1'b0; m_rstn = 1'b1; m_done = 1'b0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_sum = '0;
        end else begin
            m_done = 1'b0;
            m_we   = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_t = 1;
                    m_base = base_addr; m_cnt = word_count; m_addr = base_addr;
                    m_left = int'(word_count); m_err = 1'b0; m_sum = '0;
                end
            end else begin
                if (m_t == 1) begin
                    if (m_cnt == 0 || int'(m_base) + int'(m_cnt) > 1024) begin
                        m_err = 1'b1; m_active = 1'b0;
                    end else begin
                        m_rstn = 1'b0;
                    end
                end else if (m_left == 0) begin
                    m_active = 1'b0; m_done = 1'b1; m_rstn = 1'b1;
                end else if (abort) begin
                    m_err = 1'b1; m_active = 1'b0;
                end else if (m_t >= 4 && wvalid) begin
                    m_we = 1'b1; m_waddr = m_addr; m_wdata = wdata;
                    m_addr = m_addr + 1'b1; m_left--; m_sum = m_sum + wdata;
                end
                m_t++;
            end
        end
    end

    // ---------------- compare process + observation log ----------------
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];
    int done_cyc, lo_first, lo_last, err_first;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wready", wready, m_active && m_t >= 4 && m_left > 0);
            chk("busy", busy, m_active);
            chk("mem_we", mem_we, m_we);
            if (m_we) begin
                chk("mem_addr", mem_addr, m_waddr);
                chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("pmcc_rst_n", pmcc_rst_n, m_rstn);
            chk("done", done, m_done);
            chk("error", error, m_err);
`ifdef PMC_LOADER_CHECKSUM_EN
            chk("checksum", checksum, m_sum);
`endif
        end
        if (mem_we === 1'b1) begin
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
        if (done === 1'b1) done_cyc = cyc - t0;
        if (error === 1'b1 && err_first < 0) err_first = cyc - t0;
        if (pmcc_rst_n === 1'b0) begin
            if (lo_first < 0) lo_first = cyc - t0;
            lo_last = cyc - t0;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] src_words[$];
    int src_idx   = 0;
    bit src_on    = 1'b0;
    bit src_gap   = 1'b0;
    bit src_phase = 1'b0;

    task automatic drive_src();
        wvalid = src_on && (src_idx < src_words.size()) && (!src_gap || src_phase);
        wdata  = (src_idx < src_words.size()) ? src_words[src_idx] : '0;
    endtask

    task automatic step();
        logic hs;
        @(negedge clk);
        hs = wvalid && wready;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (hs) src_idx++;
        src_phase = !src_phase;
        drive_src();
    endtask

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete();
        done_cyc = -1; lo_first = -1; lo_last = -1; err_first = -1;
    endtask

    task automatic begin_session(logic [AW-1:0] b, logic [AW:0] n, bit gap);
        clear_logs();
        src_idx = 0; src_on = 1'b1; src_gap = gap; src_phase = 1'b0;
        base_addr = b; word_count = n; start = 1'b1; t0 = cyc;
        drive_src();
    endtask

    task automatic chk_writes(string nm, int b, int n);
        chk({nm, "_count"}, wlog_a.size(), n);
        for (int i = 0; i < n && i < wlog_a.size(); i++) begin
            chk({nm, "_addr"}, wlog_a[i], b + i);
            chk({nm, "_data"}, wlog_d[i], src_words[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wvalid = 1'b0; wdata = '0;
        base_addr = '0; word_count = '0;
        clear_logs();
        step(); step();
        chk_en = 1'b1;
        step();
        chk("rst_pmcc", pmcc_rst_n, 1'b1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();

        // nominal load
        src_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        begin_session(10'h010, 11'd4, 1'b0);
        repeat (12) step();
        chk_writes("nominal", 'h010, 4);
        chk("nominal_done_cycle", done_cyc, 9);
        chk("nominal_rst_lo_first", lo_first, 2);
        chk("nominal_rst_lo_last", lo_last, 8);
        chk("nominal_error", error, 1'b0);

        // backpressure gaps
        src_words = '{32'hB0, 32'hB1, 32'hB2};
        begin_session(10'h020, 11'd3, 1'b1);
        repeat (16) step();
        chk_writes("gaps", 'h020, 3);
        chk("gaps_pmcc", pmcc_rst_n, 1'b1);

        // range error
        src_words = '{32'hE0, 32'hE1, 32'hE2};
        begin_session(10'h3FE, 11'd3, 1'b0);
        repeat (6) step();
        chk("range_err_cycle", err_first, 2);
        chk("range_writes", wlog_a.size(), 0);
        chk("range_done", done_cyc, -1);
        chk("range_rst_lo", lo_first, -1);

        // full depth
        src_words.delete();
        for (int i = 0; i < 1024; i++) src_words.push_back(32'h5A5A_0000 ^ 32'(i * 7));
        begin_session(10'h000, 11'd1024, 1'b0);
        repeat (1040) step();
        chk("full_count", wlog_a.size(), 1024);
        chk("full_last_addr", wlog_a[wlog_a.size() - 1], 10'h3FF);
        chk("full_last_data", wlog_d[wlog_d.size() - 1], 32'h5A5A_0000 ^ 32'(1023 * 7));
        chk("full_done_cycle", done_cyc, 1029);
        chk("full_error", error, 1'b0);

        // zero word count
        begin_session(10'h000, 11'd0, 1'b0);
        repeat (6) step();
        chk("zero_err_cycle", err_first, 2);
        chk("zero_writes", wlog_a.size(), 0);

        // abort with a handshake on the 2nd of 4 words
        src_words = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        begin_session(10'h040, 11'd4, 1'b0);
        repeat (5) step();
        abort = 1'b1;
        src_on = 1'b0;
        step();
        repeat (6) step();
        chk_writes("abort", 'h040, 1);
        chk("abort_error", error, 1'b1);
        chk("abort_done", done_cyc, -1);
        chk("abort_pmcc", pmcc_rst_n, 1'b0);

        // new start clears error
        src_words = '{32'hD0};
        begin_session(10'h050, 11'd1, 1'b0);
        step();
        chk("restart_error_clr", error, 1'b0);
        repeat (8) step();
        chk_writes("restart", 'h050, 1);
        chk("restart_done_cycle", done_cyc, 6);
        chk("restart_pmcc", pmcc_rst_n, 1'b1);

        // reset in the middle of a load
        src_words = '{32'h60, 32'h61, 32'h62, 32'h63};
        begin_session(10'h060, 11'd4, 1'b0);
        repeat (6) step();
        rst_n = 1'b0;
        step();
        chk("midrst_pmcc", pmcc_rst_n, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_we", mem_we, 1'b0);
        rst_n = 1'b1;
        src_on = 1'b0;
        step(); step();

`ifdef PMC_LOADER_CHECKSUM_EN
        src_words = '{32'hFFFF_FFFF, 32'h0000_0002};
        begin_session(10'h070, 11'd2, 1'b0);
        repeat (10) step();
        chk("checksum_done_cycle", done_cyc, 7);
        chk("checksum_value", checksum, 32'h0000_0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
